// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg -- shared constants and helpers for the FIFO drain block.
//
// Contents:
//   MAX_RD_LATENCY  largest supported FIFO read latency (legal range 1..3)
//   MAX_BUF_DEPTH   largest skid-buffer depth (MAX_RD_LATENCY + 1)
//   PTR_W           pointer width, wide enough for every legal buffer depth
//   OCC_W           occupancy / in-flight counter width (holds 0..MAX_BUF_DEPTH)
//   buf_depth()     buffer depth needed to stream one word per cycle
//   ptr_wrap_inc()  pointer increment modulo an arbitrary (non power-of-2) depth
package fifo_drain_pkg;

  localparam int MAX_RD_LATENCY = 3;
  localparam int MAX_BUF_DEPTH  = MAX_RD_LATENCY + 1;
  localparam int PTR_W          = $clog2(MAX_BUF_DEPTH);
  localparam int OCC_W          = $clog2(MAX_BUF_DEPTH + 1);

  // One slot per read that can be in flight plus one for the word being
  // presented downstream; that keeps reads flowing every cycle while the
  // consumer accepts every cycle.
  function automatic int buf_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

  // Depth is 2..4, so the wrap point is explicit rather than relying on
  // the natural overflow of the pointer register.
  function automatic logic [PTR_W-1:0] ptr_wrap_inc(input logic [PTR_W-1:0] ptr,
                                                    input int depth);
    if (ptr == PTR_W'(depth - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/i_fifo.sv
// i_fifo -- read-side view of a synchronous FIFO with a fixed read latency.
//
// Signals:
//   rd_en      pop request from the consumer
//   empty      FIFO holds no words
//   alm_empty  FIFO almost empty (informational)
//   data_out   popped word, valid a fixed number of cycles after rd_en
//   count      number of words held (informational)
//
// Modports:
//   to_consumer  the block that drains the FIFO
//   to_fifo      the FIFO itself
interface i_fifo #(
  parameter int DATA_WIDTH  = 512,
  parameter int COUNT_WIDTH = 32
);

  logic                   rd_en;
  logic                   empty;
  logic                   alm_empty;
  logic [DATA_WIDTH-1:0]  data_out;
  logic [COUNT_WIDTH-1:0] count;

  modport to_consumer (
    output rd_en,
    input  empty,
    input  alm_empty,
    input  data_out,
    input  count
  );

  modport to_fifo (
    input  rd_en,
    output empty,
    output alm_empty,
    output data_out,
    output count
  );

endinterface

// File: rtl/drain_buf.sv
// drain_buf -- small register-based FIFO that catches words landing from the
// upstream FIFO and presents the oldest one to the downstream consumer.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset_n    asynchronous active-low reset (pointers and occupancy)
//   push       write push_data this cycle (caller guarantees a free slot,
//              counting a same-cycle pop)
//   push_data  word to write
//   pop        remove the head entry this cycle (caller guarantees occupancy>0)
//   head_data  oldest entry; meaningful only while occupancy != 0
//   occupancy  number of entries held, 0..DEPTH
module drain_buf
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Storage is data only; it needs no reset because occupancy gates its use.
  // When the buffer is full, wr_ptr equals rd_ptr; a push is only issued in
  // that state together with a pop, and the head has already been presented
  // combinationally before the edge overwrites the slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_wrap_inc(wr_ptr, DEPTH);
      end
      if (pop) begin
        rd_ptr <= ptr_wrap_inc(rd_ptr, DEPTH);
      end
      // push and pop together leave the count unchanged
      occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain -- pulls words out of a fixed-latency FIFO and streams them to a
// valid/ready consumer, sustaining one word per cycle.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset_n    asynchronous active-low reset; deassertion synchronised outside
//   fifo       consumer end of the FIFO (drives rd_en; samples empty,
//              alm_empty, data_out, count)
//   enable     permits new FIFO reads; reads already issued still complete
//   out_valid  out_data holds a valid word
//   out_ready  consumer accepts the word this cycle
//   out_data   oldest buffered word
//   idle       registered: nothing buffered and no reads in flight
//   words_out  count of completed output transfers, wraps silently
//
// Handshake: a word moves downstream on every rising edge where out_valid and
// out_ready are both high. out_valid does not depend on out_ready, and while
// out_valid is high without out_ready the word on out_data is held unchanged.
//
// Reads are issued on credit: a read is allowed only if, after this cycle's
// landing and this cycle's transfer, the buffer plus the reads still in the
// latency pipe leave a free slot. The buffer can therefore never overflow.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int COUNT_WIDTH = 32,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  i_fifo.to_consumer             fifo,
  input  logic                   enable,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   idle,
  output logic [COUNT_WIDTH-1:0] words_out
);

  localparam int BUF_DEPTH = buf_depth(RD_LATENCY);

  // Bit 0 is the read issued last cycle; bit RD_LATENCY-1 is the read whose
  // data is on fifo.data_out this cycle.
  logic [RD_LATENCY-1:0] inflight;
  logic [RD_LATENCY-1:0] inflight_next;

  logic                  push;
  logic                  pop;
  logic                  rd_en;
  logic [OCC_W-1:0]      occupancy;
  logic [OCC_W-1:0]      occ_next;
  logic [OCC_W-1:0]      pending;
  logic [OCC_W:0]        credit_sum;
  logic [DATA_WIDTH-1:0] head_data;
  logic [COUNT_WIDTH-1:0] words_cnt;
  logic                  idle_q;

  // alm_empty and count are part of the FIFO view but play no part here.
  logic unused_fifo_status;
  assign unused_fifo_status = fifo.alm_empty ^ (^fifo.count);

  assign push = inflight[RD_LATENCY-1];
  assign pop  = out_valid & out_ready;

  // Reads still travelling after this cycle, i.e. excluding the one landing
  // now (that one is counted through push instead).
  always_comb begin
    pending = '0;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      pending = pending + OCC_W'(inflight[i]);
    end
  end

  // pop implies occupancy >= 1, so the subtraction cannot underflow.
  assign credit_sum = {1'b0, occupancy} + {1'b0, pending}
                    + (OCC_W+1)'(push) - (OCC_W+1)'(pop);

  // reset_n gates the request so no read is issued while held in reset.
  assign rd_en = reset_n & enable & ~fifo.empty
               & (credit_sum < (OCC_W+1)'(BUF_DEPTH));

  assign fifo.rd_en = rd_en;

  always_comb begin
    inflight_next    = '0;
    inflight_next[0] = rd_en;
    for (int i = 1; i < RD_LATENCY; i++) begin
      inflight_next[i] = inflight[i-1];
    end
  end

  assign occ_next = occupancy + OCC_W'(push) - OCC_W'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight  <= '0;
      words_cnt <= '0;
      idle_q    <= 1'b1;
    end else begin
      inflight <= inflight_next;
      if (pop) begin
        words_cnt <= words_cnt + COUNT_WIDTH'(1);
      end
      // idle is a flop so it never combinationally follows enable/out_ready
      idle_q <= (occ_next == '0) && (inflight_next == '0);
    end
  end

  drain_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (fifo.data_out),
    .pop       (pop),
    .head_data (head_data),
    .occupancy (occupancy)
  );

  assign out_valid = (occupancy != '0);
  assign out_data  = head_data;
  assign idle      = idle_q;
  assign words_out = words_cnt;

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain -- directed bench for fifo_drain. Two instances: dut_a with
// RD_LATENCY=1 and an 8-bit transfer counter, dut_b with RD_LATENCY=3 and a
// 5-bit counter so the counter wrap is reachable. Each has a small behavioural
// FIFO model with the matching read latency.
module tb_fifo_drain;

  localparam int DW   = 32;
  localparam int CW_A = 8;
  localparam int CW_B = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- DUT A (latency 1) ----------------
  i_fifo #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW_A)) fa ();
  logic            a_en, a_ready, a_valid, a_idle;
  logic [DW-1:0]   a_data;
  logic [CW_A-1:0] a_words;

  fifo_drain #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW_A), .RD_LATENCY(1)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .fifo      (fa.to_consumer),
    .enable    (a_en),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .out_data  (a_data),
    .idle      (a_idle),
    .words_out (a_words)
  );

  // ---------------- DUT B (latency 3) ----------------
  i_fifo #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW_B)) fb ();
  logic            b_en, b_ready, b_valid, b_idle;
  logic [DW-1:0]   b_data;
  logic [CW_B-1:0] b_words;

  fifo_drain #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW_B), .RD_LATENCY(3)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .fifo      (fb.to_consumer),
    .enable    (b_en),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .out_data  (b_data),
    .idle      (b_idle),
    .words_out (b_words)
  );

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] fq_a[$];   // contents of FIFO model A
  logic [DW-1:0] exp_a[$];  // words still expected from dut_a, in order
  logic [DW-1:0] fq_b[$];
  logic [DW-1:0] exp_b[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- FIFO models ----------------
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fq_a.delete();
      fa.empty     <= 1'b1;
      fa.alm_empty <= 1'b1;
      fa.count     <= '0;
      fa.data_out  <= '0;
    end else begin
      if (fa.rd_en) begin
        check("a_rd_nonempty", 64'(fq_a.size() != 0), 64'd1);
        if (fq_a.size() != 0) fa.data_out <= fq_a.pop_front();
      end else begin
        fa.data_out <= 32'hBAD0_0000;
      end
      fa.empty     <= (fq_a.size() == 0);
      fa.alm_empty <= (fq_a.size() <= 1);
      fa.count     <= CW_A'(fq_a.size());
    end
  end

  logic [DW-1:0] pop_b, pb0, pb1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fq_b.delete();
      pb0          <= '0;
      pb1          <= '0;
      fb.empty     <= 1'b1;
      fb.alm_empty <= 1'b1;
      fb.count     <= '0;
      fb.data_out  <= '0;
    end else begin
      pop_b = 32'hBAD0_0001;
      if (fb.rd_en) begin
        check("b_rd_nonempty", 64'(fq_b.size() != 0), 64'd1);
        if (fq_b.size() != 0) pop_b = fq_b.pop_front();
      end
      pb0          <= pop_b;
      pb1          <= pb0;
      fb.data_out  <= pb1;
      fb.empty     <= (fq_b.size() == 0);
      fb.alm_empty <= (fq_b.size() <= 1);
      fb.count     <= CW_B'(fq_b.size());
    end
  end

  // ---------------- output monitors ----------------
  logic          a_stall = 1'b0;
  logic [DW-1:0] a_hold;
  always @(negedge clk) begin
    if (reset_n) begin
      if (a_stall) begin
        check("a_stall_valid", 64'(a_valid), 64'd1);
        check("a_stall_data", 64'(a_data), 64'(a_hold));
      end
      if (a_valid && a_ready) begin
        if (exp_a.size() == 0) check("a_unexpected_word", 64'(a_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("a_data", 64'(a_data), 64'(exp_a.pop_front()));
      end
      a_stall = a_valid && !a_ready;
      a_hold  = a_data;
    end else begin
      a_stall = 1'b0;
    end
  end

  logic          b_stall = 1'b0;
  logic [DW-1:0] b_hold;
  always @(negedge clk) begin
    if (reset_n) begin
      if (b_stall) begin
        check("b_stall_valid", 64'(b_valid), 64'd1);
        check("b_stall_data", 64'(b_data), 64'(b_hold));
      end
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) check("b_unexpected_word", 64'(b_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("b_data", 64'(b_data), 64'(exp_b.pop_front()));
      end
      b_stall = b_valid && !b_ready;
      b_hold  = b_data;
    end else begin
      b_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload_a(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fq_a.push_back(base + DW'(i));
      exp_a.push_back(base + DW'(i));
    end
  endtask

  task automatic preload_b_random(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom();
      fq_b.push_back(w);
      exp_b.push_back(w);
    end
  endtask

  task automatic wait_a_drained(input string tag, input int budget);
    int n = 0;
    while (!(exp_a.size() == 0 && a_idle) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(exp_a.size() == 0 && a_idle), 64'd1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_a_valid"}, 64'(a_valid), 64'd0);
    check({tag, "_a_words"}, 64'(a_words), 64'd0);
    check({tag, "_a_idle"},  64'(a_idle),  64'd1);
    check({tag, "_a_rd_en"}, 64'(fa.rd_en), 64'd0);
    check({tag, "_b_valid"}, 64'(b_valid), 64'd0);
    check({tag, "_b_words"}, 64'(b_words), 64'd0);
    check({tag, "_b_idle"},  64'(b_idle),  64'd1);
    check({tag, "_b_rd_en"}, 64'(fb.rd_en), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic pat[4];
  int   n;
  int   cnt;

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    a_en = 1'b0; a_ready = 1'b0;
    b_en = 1'b0; b_ready = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2 reset_checks("rst");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // empty FIFO with enable high: no reads, nothing out
    a_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("empty_rd_en", 64'(fa.rd_en), 64'd0);
      check("empty_valid", 64'(a_valid), 64'd0);
      check("empty_idle", 64'(a_idle), 64'd1);
    end

    // streaming 0..15 with out_ready held high
    @(posedge clk); #1;
    a_ready = 1'b1;
    preload_a(16, 32'd0);
    n = 0;
    @(negedge clk);
    while (!a_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("stream_start", 64'(a_valid), 64'd1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("stream_cont", 64'(a_valid), 64'd1);
    end
    @(negedge clk);
    check("stream_end_valid", 64'(a_valid), 64'd0);
    check("stream_words", 64'(a_words), 64'd16);
    check("stream_idle", 64'(a_idle), 64'd1);
    check("stream_drained", 64'(exp_a.size()), 64'd0);

    // backpressure: out_ready 1,0,0,1 repeating
    @(posedge clk); #1;
    preload_a(16, 32'h100);
    for (int c = 0; c < 300 && !(exp_a.size() == 0 && a_idle); c++) begin
      a_ready = pat[c % 4];
      @(posedge clk); #1;
    end
    check("bp_done", 64'(exp_a.size() == 0 && a_idle), 64'd1);
    check("bp_words", 64'(a_words), 64'd32);
    a_ready = 1'b1;

    // enable dropped right after the third read
    a_en = 1'b0;
    preload_a(8, 32'h200);
    repeat (2) @(posedge clk);
    #1 a_en = 1'b1;
    cnt = 0;
    n   = 0;
    while (cnt < 3 && n < 20) begin
      @(negedge clk);
      if (fa.rd_en) cnt++;
      n++;
    end
    check("drop_three_reads", 64'(cnt), 64'd3);
    @(posedge clk); #1;
    a_en = 1'b0;
    repeat (8) @(negedge clk);
    check("drop_words", 64'(a_words), 64'd35);
    check("drop_idle", 64'(a_idle), 64'd1);
    check("drop_valid", 64'(a_valid), 64'd0);
    check("drop_rd_en", 64'(fa.rd_en), 64'd0);
    check("drop_fifo_left", 64'(fq_a.size()), 64'd5);
    @(posedge clk); #1;
    a_en = 1'b1;
    wait_a_drained("drop_resume_drain", 40);
    check("drop_resume_words", 64'(a_words), 64'd40);

    // reset asserted with words buffered and stalled
    a_ready = 1'b0;
    preload_a(4, 32'h300);
    repeat (6) @(posedge clk);
    #1;
    check("prerst_valid", 64'(a_valid), 64'd1);
    check("prerst_data", 64'(a_data), 64'h300);
    reset_n = 1'b0;
    #1;
    reset_checks("midrst");
    exp_a.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    a_ready = 1'b1;
    preload_a(3, 32'h400);
    wait_a_drained("postrst_drain", 30);
    check("postrst_words", 64'(a_words), 64'd3);

    // latency 3: random words, random out_ready
    @(posedge clk); #1;
    b_en = 1'b1;
    preload_b_random(32);
    for (int c = 0; c < 600 && !(exp_b.size() == 0 && b_idle); c++) begin
      b_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    check("lat3_rand_done", 64'(exp_b.size() == 0 && b_idle), 64'd1);
    check("lat3_rand_words_wrap", 64'(b_words), 64'd0);

    // latency 3: back-to-back throughput and counter wrap 31 -> 0
    b_ready = 1'b1;
    preload_b_random(32);
    n = 0;
    @(negedge clk);
    while (!b_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("lat3_stream_start", 64'(b_valid), 64'd1);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      check("lat3_stream_cont", 64'(b_valid), 64'd1);
      if (i == 31) check("lat3_words_max", 64'(b_words), 64'd31);
    end
    @(negedge clk);
    check("lat3_stream_end", 64'(b_valid), 64'd0);
    check("lat3_words_wrapped", 64'(b_words), 64'd0);
    check("lat3_idle", 64'(b_idle), 64'd1);
    check("lat3_drained", 64'(exp_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
